// File: rtl/dsa_pkg.sv
// Shared types for the DSA signing scheduler.
package dsa_pkg;
    localparam int DSA_LEN = 64;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first set request at or after ptr, with wrap.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    logic          found;
    logic [PW:0]   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!found && req[idx[PW-1:0]]) begin
                found               = 1'b1;
                gnt[idx[PW-1:0]]    = 1'b1;
                gnt_idx             = idx[PW-1:0];
            end
        end
    end
endmodule

// File: rtl/dsa_sign_sched.sv
// Shares one dsa_sign engine between NREQ requesters with a job watchdog.
module dsa_sign_sched
    import dsa_pkg::*;
#(
    parameter int LEN     = DSA_LEN,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LEN-1:0]  req_x,
    input  logic [NREQ*LEN-1:0]  req_k,
    input  logic [NREQ*LEN-1:0]  req_z,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [LEN-1:0]       rsp_r,
    output logic [LEN-1:0]       rsp_s,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 eng_start,
    output logic [LEN-1:0]       eng_x,
    output logic [LEN-1:0]       eng_k,
    output logic [LEN-1:0]       eng_z,
    input  logic [LEN-1:0]       eng_r,
    input  logic [LEN-1:0]       eng_s,
    input  logic                 eng_done
);
    localparam int PW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);

    sched_state_t state_q, state_d;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [WW-1:0]   wd_q, wd_d, wd_inc;
    logic            err_q, err_d;
    logic [LEN-1:0]  res_r_q, res_r_d;
    logic [LEN-1:0]  res_s_q, res_s_d;
    logic [LEN-1:0]  ex_q, ex_d, ek_q, ek_d, ez_q, ez_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] rv_q, rv_d;
    logic [LEN-1:0]  rr_q, rr_d, rs_q, rs_d;
    logic            rerr_q, rerr_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;

    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            in_wait, wd_hit, done_ok;

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign in_wait = (state_q == WAIT_CLR) || (state_q == WAIT_DONE);
    assign wd_inc  = (wd_q == WW'(TIMEOUT)) ? wd_q : wd_q + 1'b1;
    assign wd_hit  = in_wait && (wd_inc == WW'(TIMEOUT));
    // A done seen in WAIT_CLR is stale; only WAIT_DONE may complete a job.
    assign done_ok = (state_q == WAIT_DONE) && eng_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (|req) state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (wd_hit) state_d = RESP;
                else if (!eng_done) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_done || wd_hit) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wd_d    = wd_q;
        err_d   = err_q;
        res_r_d = res_r_q;
        res_s_d = res_s_q;
        ex_d    = ex_q;
        ek_d    = ek_q;
        ez_d    = ez_q;
        ack_d   = '0;
        rv_d    = '0;
        rr_d    = '0;
        rs_d    = '0;
        rerr_d  = 1'b0;
        busy_d  = (state_q != IDLE);
        start_d = (state_q == LAUNCH);
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    ack_d   = gnt;
                    owner_d = gnt_idx;
                    ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    ex_d    = req_x[int'(gnt_idx)*LEN +: LEN];
                    ek_d    = req_k[int'(gnt_idx)*LEN +: LEN];
                    ez_d    = req_z[int'(gnt_idx)*LEN +: LEN];
                end
            end
            LAUNCH: begin
                wd_d  = '0;
                err_d = 1'b0;
            end
            WAIT_CLR, WAIT_DONE: begin
                wd_d = wd_inc;
                if (done_ok) begin
                    res_r_d = eng_r;
                    res_s_d = eng_s;
                    err_d   = 1'b0;
                end else if (wd_hit) begin
                    res_r_d = '0;
                    res_s_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                rv_d   = NREQ'(1) << owner_q;
                rerr_d = err_q;
                rr_d   = res_r_q;
                rs_d   = res_s_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            owner_q <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            res_r_q <= '0;
            res_s_q <= '0;
            ex_q    <= '0;
            ek_q    <= '0;
            ez_q    <= '0;
            ack_q   <= '0;
            rv_q    <= '0;
            rr_q    <= '0;
            rs_q    <= '0;
            rerr_q  <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            res_r_q <= res_r_d;
            res_s_q <= res_s_d;
            ex_q    <= ex_d;
            ek_q    <= ek_d;
            ez_q    <= ez_d;
            ack_q   <= ack_d;
            rv_q    <= rv_d;
            rr_q    <= rr_d;
            rs_q    <= rs_d;
            rerr_q  <= rerr_d;
            busy_q  <= busy_d;
            start_q <= start_d;
        end
    end

    assign ack       = ack_q;
    assign rsp_valid = rv_q;
    assign rsp_r     = rr_q;
    assign rsp_s     = rs_q;
    assign rsp_err   = rerr_q;
    assign busy      = busy_q;
    assign eng_start = start_q;
    assign eng_x     = ex_q;
    assign eng_k     = ek_q;
    assign eng_z     = ez_q;
endmodule

// File: tb/tb_dsa_sign_sched.sv
// Bench for dsa_sign_sched: behavioural engine plus a job-level scheduler model.
module tb_dsa_sign_sched;
    localparam int LEN  = 64;
    localparam int NREQ = 4;
    localparam int TO   = 16;
    localparam logic [63:0] P = 64'd7879;
    localparam logic [63:0] Q = 64'd101;
    localparam logic [63:0] G = 64'd170;

    typedef struct {
        int          g;
        logic [63:0] r;
        logic [63:0] s;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*LEN-1:0] req_x, req_k, req_z;
    logic [NREQ-1:0]     ack, rsp_valid;
    logic [LEN-1:0]      rsp_r, rsp_s;
    logic                rsp_err, busy, eng_start;
    logic [LEN-1:0]      eng_x, eng_k, eng_z;
    logic [LEN-1:0]      eng_r, eng_s;
    logic                eng_done;

    dsa_sign_sched #(.LEN(LEN), .NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .req_k     (req_k),
        .req_z     (req_z),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_r     (rsp_r),
        .rsp_s     (rsp_s),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .eng_start (eng_start),
        .eng_x     (eng_x),
        .eng_k     (eng_k),
        .eng_z     (eng_z),
        .eng_r     (eng_r),
        .eng_s     (eng_s),
        .eng_done  (eng_done)
    );

    function automatic logic [63:0] mpow(logic [63:0] b, logic [63:0] e,
                                         logic [63:0] m);
        logic [127:0] acc, bb;
        acc = 128'd1;
        bb  = {64'd0, b % m};
        while (e != 0) begin
            if (e[0]) acc = (acc * bb) % {64'd0, m};
            bb = (bb * bb) % {64'd0, m};
            e  = e >> 1;
        end
        return acc[63:0];
    endfunction

    function automatic logic [63:0] dsa_r(logic [63:0] k);
        return mpow(G, k, P) % Q;
    endfunction

    function automatic logic [63:0] dsa_s(logic [63:0] x, logic [63:0] k,
                                          logic [63:0] z);
        logic [127:0] t;
        t = ({64'd0, z} + {64'd0, x} * {64'd0, dsa_r(k)}) % {64'd0, Q};
        t = ({64'd0, mpow(k, Q - 2, Q)} * t) % {64'd0, Q};
        return t[63:0];
    endfunction

    // Behavioural engine: done holds until the next start; optional stale hold / hang.
    int          e_lat, e_stick;
    bit          e_never;
    logic        e_done = 1'b0;
    logic [63:0] e_r = '0, e_s = '0, ex = '0, ek = '0, ez = '0;
    int          e_cnt = 0, e_stk = 0, n_start = 0;

    assign eng_done = e_done;
    assign eng_r    = e_r;
    assign eng_s    = e_s;

    always @(posedge clk) begin
        if (eng_start) begin
            ex      <= eng_x;
            ek      <= eng_k;
            ez      <= eng_z;
            e_cnt   <= e_lat;
            e_stk   <= e_stick;
            n_start <= n_start + 1;
            if (e_stick == 0) e_done <= 1'b0;
        end else if (e_stk > 0) begin
            e_stk <= e_stk - 1;
            if (e_stk == 1) e_done <= 1'b0;
        end else if (e_cnt > 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1 && !e_never) begin
                e_done <= 1'b1;
                e_r    <= dsa_r(ek);
                e_s    <= dsa_s(ex, ek, ez);
            end
        end
    end

    int          total = 0, bad = 0, cyc = 0, nrsp = 0;
    int          m_ptr = 0;
    bit          m_idle = 1'b1;
    bit          pend_start = 1'b0, pend_fall = 1'b0;
    exp_t        q[$];
    int          grants[$];
    logic [63:0] opx[NREQ], opk[NREQ], opz[NREQ];
    logic [63:0] last_r, last_s;
    logic        last_err;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        logic [NREQ-1:0] dp, ea;
        logic            rp;
        int              g;
        exp_t            e;
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*LEN +: LEN] = opx[i];
            req_k[i*LEN +: LEN] = opk[i];
            req_z[i*LEN +: LEN] = opz[i];
        end
        dp = req;
        rp = rst;
        @(negedge clk);
        cyc++;
        if (rp) begin
            chk("rst_ack", ack, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_eng_start", eng_start, 0);
            chk("rst_rsp_err", rsp_err, 0);
            chk("rst_eng_x", eng_x, 0);
            chk("rst_rsp_r", rsp_r, 0);
            m_idle = 1'b1;
            m_ptr = 0;
            pend_start = 1'b0;
            pend_fall = 1'b0;
            q.delete();
            return;
        end
        if (pend_start) chk("eng_start", eng_start, 1);
        if (pend_fall) chk("busy_fall", busy, 0);
        pend_start = 1'b0;
        pend_fall = 1'b0;
        ea = '0;
        g = -1;
        if (m_idle && dp != 0) begin
            g = pick(dp);
            ea[g] = 1'b1;
        end
        if (ea != 0 || ack != 0) chk("ack", ack, ea);
        if (g >= 0) begin
            chk("eng_x", eng_x, opx[g]);
            chk("eng_k", eng_k, opk[g]);
            chk("eng_z", eng_z, opz[g]);
            chk("busy_at_ack", busy, 0);
            e.g   = g;
            e.err = e_never;
            e.r   = e_never ? 64'd0 : dsa_r(opk[g]);
            e.s   = e_never ? 64'd0 : dsa_s(opx[g], opk[g], opz[g]);
            e.due = cyc + (e_never ? TO + 2 : 4 + e_lat + e_stick);
            q.push_back(e);
            grants.push_back(g);
            m_ptr = (g + 1) % NREQ;
            m_idle = 1'b0;
            pend_start = 1'b1;
            req[g] = 1'b0;
        end
        if (rsp_valid != 0) begin
            if (q.size() == 0) begin
                chk("rsp_spurious", rsp_valid, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_owner", rsp_valid, 64'd1 << e.g);
                chk("rsp_r", rsp_r, e.r);
                chk("rsp_s", rsp_s, e.s);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_cycle", cyc, e.due);
                chk("busy_at_rsp", busy, 1);
                last_r = rsp_r;
                last_s = rsp_s;
                last_err = rsp_err;
                nrsp++;
            end
            m_idle = 1'b1;
            pend_fall = 1'b1;
        end else if (q.size() > 0 && cyc >= q[0].due) begin
            chk("rsp_missing", rsp_valid, 64'd1 << q[0].g);
            void'(q.pop_front());
            m_idle = 1'b1;
        end
    endtask

    task automatic run_idle(int budget);
        int n;
        n = 0;
        while (!(m_idle && req == 0 && q.size() == 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic wait_grant(int budget);
        int n, n0;
        n = 0;
        n0 = grants.size();
        while (grants.size() == n0 && n < budget) begin
            step();
            n++;
        end
        chk("grant_in_budget", n < budget, 1);
    endtask

    task automatic set_vec(int i);
        opx[i] = 64'd75;
        opk[i] = 64'd50;
        opz[i] = 64'd42;
    endtask

    initial begin
        int n0, r0;
        rst = 1'b1;
        req = '0;
        e_lat = 3;
        e_stick = 0;
        e_never = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = '0;
            opk[i] = '0;
            opz[i] = '0;
        end
        step();
        step();
        rst = 1'b0;
        step();

        // single job from requester 2
        set_vec(2);
        req = 4'b0100;
        run_idle(40);
        chk("single_r", last_r, 94);
        chk("single_s", last_s, 57);

        // all four at once after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_vec(i);
        grants.delete();
        n0 = n_start;
        r0 = nrsp;
        req = 4'b1111;
        run_idle(120);
        for (int i = 0; i < NREQ; i++) chk("all4_order", grants[i], i);
        chk("all4_starts", n_start - n0, 4);
        chk("all4_rsps", nrsp - r0, 4);
        chk("all4_r", last_r, 94);

        // fairness: 3 beats 1 after 1 was served
        grants.delete();
        req = 4'b0010;
        wait_grant(10);
        req = 4'b1010;
        run_idle(120);
        chk("fair_0", grants[0], 1);
        chk("fair_1", grants[1], 3);
        chk("fair_2", grants[2], 1);

        // engine hang -> watchdog abort, then a good job
        e_never = 1'b1;
        set_vec(0);
        req = 4'b0001;
        run_idle(60);
        chk("to_err", last_err, 1);
        chk("to_r", last_r, 0);
        e_never = 1'b0;
        req = 4'b0100;
        run_idle(40);
        chk("after_to_r", last_r, 94);
        chk("after_to_err", last_err, 0);

        // stale done held across start
        e_stick = 4;
        opx[0] = 64'd12;
        opk[0] = 64'd77;
        opz[0] = 64'd5;
        req = 4'b0001;
        run_idle(40);
        e_stick = 0;

        // reset while waiting for done
        e_lat = 8;
        set_vec(1);
        set_vec(3);
        req = 4'b0010;
        wait_grant(10);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) begin
            step();
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        e_lat = 3;
        grants.delete();
        req = 4'b1010;
        run_idle(80);
        chk("rerq_first", grants[0], 1);
        chk("rerq_r", last_r, 94);
        chk("rerq_s", last_s, 57);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (m_idle) e_lat = $urandom_range(1, 8);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    opx[i] = 64'($urandom_range(1, 200));
                    opk[i] = 64'($urandom_range(1, 100));
                    opz[i] = 64'($urandom_range(0, 300));
                end else if (req[i] && $urandom_range(0, 29) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        run_idle(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
